// File: rtl/a2d_pkg.sv
// a2d_sched shared types: scheduler states, channel ids
// and the channel to strobe one-hot mapping.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ISSUE,
    CONV,
    DONE,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    CH_LFT,
    CH_RGHT,
    CH_STEER,
    CH_BATT
  } ch_e;

  function automatic logic [3:0] ch_onehot(input ch_e c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/a2d_tmr.sv
// Saturating up-counter; expire is high while the count
// sits at LIMIT, clr returns it to zero.
module a2d_tmr #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = (cnt == LIM);

endmodule

// File: rtl/a2d_sched.sv
// A2D conversion scheduler: periodic nxt issue, SS_n based
// completion tracking, channel strobes, batt_low, watchdog.
module a2d_sched
  import a2d_pkg::*;
#(
  parameter int          PERIOD_CYC = 4096,
  parameter int          TMO_CYC    = 2048,
  parameter logic [11:0] BATT_LO    = 12'hA98,
  parameter logic [11:0] BATT_HYST  = 12'h040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        force_swp,
  input  logic        SS_n,
  input  logic [11:0] batt,
  output logic        nxt,
  output logic [3:0]  chan_vld,
  output logic        sweep_done,
  output logic        busy,
  output logic        batt_low,
  output logic        a2d_err
);

  localparam logic [11:0] BATT_HI = BATT_LO + BATT_HYST;

  state_e state, nstate;
  ch_e    idx;
  logic   ss_q;
  logic   rise;
  logic   ecnt;
  logic   pend;
  logic   per_exp;
  logic   wd_exp;
  logic   per_clr;
  logic   wd_clr;

  assign rise    = SS_n & ~ss_q;
  assign per_clr = (state == IDLE) || (state == ISSUE)
                || (state == ERR);
  assign wd_clr  = (state != CONV);

  // The decision cycle and the ISSUE cycle both sit inside
  // each interval, so both counters stop two short.
  a2d_tmr #(.LIMIT(PERIOD_CYC - 2)) u_per (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (per_clr),
    .expire (per_exp)
  );

  a2d_tmr #(.LIMIT(TMO_CYC - 2)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .expire (wd_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= CH_LFT;
      ss_q     <= 1'b1;
      ecnt     <= 1'b0;
      pend     <= 1'b0;
      batt_low <= 1'b0;
    end else begin
      state <= nstate;
      ss_q  <= SS_n;
      if (state == ISSUE) begin
        ecnt <= 1'b0;
      end else if (state == CONV && rise) begin
        ecnt <= 1'b1;
      end
      if (state == IDLE || state == ISSUE) begin
        pend <= 1'b0;
      end else if ((state == CONV || state == DONE)
                   && (per_exp || force_swp)) begin
        pend <= 1'b1;
      end
      if (state == DONE) begin
        idx <= ch_e'(idx + 2'd1);
        if (idx == CH_BATT) begin
          if (batt < BATT_LO) begin
            batt_low <= 1'b1;
          end else if (batt >= BATT_HI) begin
            batt_low <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    nstate     = state;
    nxt        = 1'b0;
    busy       = 1'b0;
    chan_vld   = 4'b0000;
    sweep_done = 1'b0;
    a2d_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) nstate = WAIT;
      end
      WAIT: begin
        if (!en) begin
          nstate = IDLE;
        end else if (per_exp || pend || force_swp) begin
          nstate = ISSUE;
        end
      end
      ISSUE: begin
        nxt    = 1'b1;
        nstate = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (rise && ecnt) begin
          nstate = DONE;
        end else if (wd_exp) begin
          nstate = ERR;
        end
      end
      DONE: begin
        chan_vld   = ch_onehot(idx);
        sweep_done = (idx == CH_BATT);
        nstate     = en ? WAIT : IDLE;
      end
      ERR: begin
        a2d_err = 1'b1;
      end
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched with a behavioural SS_n/batt
// source standing in for A2D_intf and the SPI slave.
module tb_a2d_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        force_swp;
  logic        SS_n;
  logic [11:0] batt;
  logic        nxt;
  logic [3:0]  chan_vld;
  logic        sweep_done;
  logic        busy;
  logic        batt_low;
  logic        a2d_err;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_idx = 0;
  logic        hang = 1'b0;
  logic [11:0] slave_batt = 12'hA00;

  a2d_sched #(
    .PERIOD_CYC (64),
    .TMO_CYC    (200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .force_swp  (force_swp),
    .SS_n       (SS_n),
    .batt       (batt),
    .nxt        (nxt),
    .chan_vld   (chan_vld),
    .sweep_done (sweep_done),
    .busy       (busy),
    .batt_low   (batt_low),
    .a2d_err    (a2d_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_nxt(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound && at < 0; i++) begin
      step();
      if (nxt) at = cyc;
    end
  endtask

  task automatic conv(output int at);
    logic [3:0] v;
    logic       sw;
    int         want;
    at = -1;
    v  = '0;
    sw = 1'b0;
    for (int i = 0; i < 100 && at < 0; i++) begin
      step();
      if (chan_vld != 4'b0000) begin
        at = cyc;
        v  = chan_vld;
        sw = sweep_done;
      end
    end
    want = 1 << exp_idx;
    chk("chan_vld", {28'd0, v}, want);
    chk("sweep_done", {31'd0, sw}, (exp_idx == 3) ? 1 : 0);
    exp_idx = (exp_idx + 1) % 4;
  endtask

  // SS_n: two frames, rises 12 and 25 cycles after nxt.
  initial begin
    SS_n = 1'b1;
    batt = 12'h000;
    forever begin
      step();
      if (nxt) begin
        if (hang) begin
          SS_n = 1'b0;
          while (hang) @(posedge clk);
          #1;
          SS_n = 1'b1;
        end else begin
          repeat (2) step();
          SS_n = 1'b0;
          repeat (10) step();
          SS_n = 1'b1;
          repeat (3) step();
          SS_n = 1'b0;
          repeat (10) step();
          batt = slave_batt;
          SS_n = 1'b1;
        end
      end
    end
  end

  initial begin
    int          c, c2, d, at;
    logic [11:0] bv [6];
    logic        bl [6];
    bv = '{12'hAB0, 12'hAE0, 12'hA97, 12'hA98, 12'hAD8, 12'hA00};
    bl = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_n     = 1'b0;
    en        = 1'b0;
    force_swp = 1'b0;
    step();
    step();
    chk("reset_outs",
        {nxt, chan_vld, sweep_done, busy, batt_low, a2d_err}, 0);
    step();
    rst_n = 1'b1;
    while (cyc < 10) step();
    en = 1'b1;

    wait_nxt(100, c);
    chk("first_nxt", c, 74);
    step();
    chk("busy_conv", {31'd0, busy}, 1);
    conv(at);
    chk("first_vld_cyc", at, 100);

    for (int k = 1; k < 4; k++) begin
      wait_nxt(100, c2);
      chk("nxt_spacing", c2 - c, 64);
      c = c2;
      conv(at);
    end
    step();
    chk("batt_low_a00", {31'd0, batt_low}, 1);

    for (int s = 0; s < 5; s++) begin
      slave_batt = bv[s];
      for (int k = 0; k < 4; k++) conv(at);
      step();
      chk("batt_low_hyst", {31'd0, batt_low}, {31'd0, bl[s]});
    end

    repeat (10) step();
    d = cyc;
    force_swp = 1'b1;
    wait_nxt(5, c);
    force_swp = 1'b0;
    chk("force_wait_nxt", c - d, 1);
    conv(at);
    wait_nxt(100, c2);
    chk("after_force_period", c2 - c, 64);
    repeat (5) step();
    force_swp = 1'b1;
    step();
    force_swp = 1'b0;
    conv(d);
    wait_nxt(10, c);
    chk("force_conv_nxt", c - d, 2);
    conv(at);

    wait_nxt(100, c);
    repeat (5) step();
    en = 1'b0;
    conv(at);
    step();
    chk("busy_after_dis", {31'd0, busy}, 0);
    wait_nxt(200, c);
    chk("no_nxt_dis", c, -1);

    en = 1'b1;
    wait_nxt(100, c);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs",
        {nxt, chan_vld, sweep_done, busy, batt_low, a2d_err}, 0);
    step();
    rst_n = 1'b1;
    exp_idx = 0;
    wait_nxt(100, c);
    conv(at);

    hang = 1'b1;
    wait_nxt(100, c);
    at = -1;
    for (int i = 0; i < 300 && at < 0; i++) begin
      step();
      if (a2d_err) at = cyc;
    end
    chk("wd_err_cyc", at - c, 200);
    chk("err_not_busy", {31'd0, busy}, 0);
    wait_nxt(1000, c2);
    chk("no_nxt_err", c2, -1);
    chk("err_sticky", {31'd0, a2d_err}, 1);
    rst_n = 1'b0;
    #1;
    chk("err_rst", {31'd0, a2d_err}, 0);
    hang = 1'b0;
    en = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
